// File: rtl/addsub_step_counter_if.sv
// Control and status bundle for addsub_step_counter.
// The master drives the step controls; the slave (the counter) returns count and flags.
interface addsub_step_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             sub;
  logic [WIDTH-1:0] step;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             ovf;
  logic             tc;
  logic             zero;

  modport master (
    output en, sub, step, sat_mode, load, load_val,
    input  count, ovf, tc, zero
  );

  modport slave (
    input  en, sub, step, sat_mode, load, load_val,
    output count, ovf, tc, zero
  );
endinterface

// File: rtl/addsub_step_counter.sv
// Registered up/down counter on a two's-complement add/subtract datapath
// with programmable modulus, clamped step, wrap/saturate mode and synchronous load.
module addsub_step_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  addsub_step_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MAX_VAL + 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] step_s;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   r;
  logic             crossed;
  logic [WIDTH-1:0] load_s;

  // B XOR sub with carry-in = sub; in subtract mode r[WIDTH] is the
  // carry-out, so a clear carry means count < step (borrow).
  always_comb begin
    step_s  = (bus.step > MAX_W) ? MAX_W : bus.step;
    b_x     = step_s ^ {WIDTH{bus.sub}};
    r       = {1'b0, count_q} + {1'b0, b_x} + {{WIDTH{1'b0}}, bus.sub};
    crossed = bus.sub ? ~r[WIDTH] : (r > {1'b0, MAX_W});
    load_s  = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = load_s;
      ovf_d   = 1'b0;
    end else if (bus.en) begin
      ovf_d = crossed;
      tc_d  = crossed;
      if (!crossed) begin
        count_d = r[WIDTH-1:0];
      end else if (bus.sat_mode) begin
        count_d = bus.sub ? '0 : MAX_W;
      end else begin
        // Folding back by the modulus lands in 0..MAX_VAL; the dropped
        // top bit only carries the borrow/overflow already consumed.
        count_d = WIDTH'(bus.sub ? (r + MOD_W) : (r - MOD_W));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.tc    = tc_q;
  assign bus.zero  = (count_q == '0);

endmodule

// File: tb/tb_addsub_step_counter.sv
// Bench for addsub_step_counter: 4-bit mod-10 and 8-bit mod-256 instances
// checked every cycle against an integer model plus directed literal checks.
module tb_addsub_step_counter;

  logic clk;
  logic rst_n;

  addsub_step_counter_if #(.WIDTH(4)) bus4();
  addsub_step_counter_if #(.WIDTH(8)) bus8();

  addsub_step_counter #(.WIDTH(4), .MAX_VAL(9)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  addsub_step_counter #(.WIDTH(8), .MAX_VAL(255)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int cnt;
    bit ovf;
    bit tc;
  } mstate_t;

  function automatic mstate_t model_next(mstate_t cur, int maxv, bit ld, int lv,
                                         bit en, bit sb, int stp, bit sat);
    mstate_t n;
    int s;
    int v;
    n    = cur;
    n.tc = 1'b0;
    if (ld) begin
      n.cnt = (lv > maxv) ? maxv : lv;
      n.ovf = 1'b0;
    end else if (en) begin
      s = (stp > maxv) ? maxv : stp;
      v = sb ? cur.cnt - s : cur.cnt + s;
      if (v > maxv) begin
        n.cnt = sat ? maxv : v - (maxv + 1);
        n.ovf = 1'b1;
        n.tc  = 1'b1;
      end else if (v < 0) begin
        n.cnt = sat ? 0 : v + (maxv + 1);
        n.ovf = 1'b1;
        n.tc  = 1'b1;
      end else begin
        n.cnt = v;
        n.ovf = 1'b0;
      end
    end
    return n;
  endfunction

  mstate_t m4 = '{0, 1'b0, 1'b0};
  mstate_t m8 = '{0, 1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 <= '{0, 1'b0, 1'b0};
      m8 <= '{0, 1'b0, 1'b0};
    end else begin
      m4 <= model_next(m4, 9, bus4.load, int'(bus4.load_val), bus4.en, bus4.sub,
                       int'(bus4.step), bus4.sat_mode);
      m8 <= model_next(m8, 255, bus8.load, int'(bus8.load_val), bus8.en, bus8.sub,
                       int'(bus8.step), bus8.sat_mode);
    end
  end

  always @(negedge clk) begin
    chk("m4_count", int'(bus4.count), m4.cnt);
    chk("m4_ovf",   int'(bus4.ovf),   int'(m4.ovf));
    chk("m4_tc",    int'(bus4.tc),    int'(m4.tc));
    chk("m4_zero",  int'(bus4.zero),  int'(m4.cnt == 0));
    chk("m8_count", int'(bus8.count), m8.cnt);
    chk("m8_ovf",   int'(bus8.ovf),   int'(m8.ovf));
    chk("m8_tc",    int'(bus8.tc),    int'(m8.tc));
    chk("m8_zero",  int'(bus8.zero),  int'(m8.cnt == 0));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input bit ld, input int lv, input bit en, input bit sb,
                        input int stp, input bit sat);
    bus4.load     = ld;
    bus4.load_val = 4'(lv);
    bus4.en       = en;
    bus4.sub      = sb;
    bus4.step     = 4'(stp);
    bus4.sat_mode = sat;
  endtask

  task automatic expect4(input string nm, input int c, input int o, input int t);
    chk({nm, "_count"}, int'(bus4.count), c);
    chk({nm, "_ovf"},   int'(bus4.ovf),   o);
    chk({nm, "_tc"},    int'(bus4.tc),    t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    int pulse_at;
    rst_n = 1'b0;
    drive4(0, 0, 0, 0, 0, 0);
    bus8.load = 1'b0; bus8.load_val = '0; bus8.en = 1'b0;
    bus8.sub = 1'b0; bus8.step = '0; bus8.sat_mode = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    expect4("reset", 0, 0, 0);
    chk("reset_zero", int'(bus4.zero), 1);

    // Async reset mid-count
    drive4(1, 6, 0, 0, 0, 0); cyc();
    drive4(0, 0, 0, 0, 0, 0);
    chk("pre_rst_count", int'(bus4.count), 6);
    #2 rst_n = 1'b0;
    #1;
    expect4("async_rst", 0, 0, 0);
    chk("async_rst_zero", int'(bus4.zero), 1);
    #3 rst_n = 1'b1;

    // Wrap up-count past 9
    drive4(1, 8, 0, 0, 0, 0); cyc();
    drive4(0, 0, 1, 0, 5, 0); cyc();
    expect4("wrap_up", 3, 1, 1);
    drive4(0, 0, 0, 0, 0, 0); cyc();
    expect4("wrap_up_idle", 3, 1, 0);

    // Wrap and saturate below zero
    drive4(1, 2, 0, 0, 0, 0); cyc();
    drive4(0, 0, 1, 1, 5, 0); cyc();
    expect4("wrap_down", 7, 1, 1);
    drive4(1, 2, 0, 0, 0, 0); cyc();
    drive4(0, 0, 1, 1, 5, 1); cyc();
    expect4("sat_down", 0, 1, 1);
    chk("sat_down_zero", int'(bus4.zero), 1);

    // Saturate at top, then zero step clears flags
    drive4(1, 7, 0, 0, 0, 0); cyc();
    drive4(0, 0, 1, 0, 3, 1); cyc();
    expect4("sat_up", 9, 1, 1);
    drive4(0, 0, 1, 0, 0, 1); cyc();
    expect4("step0", 9, 0, 0);

    // Load beats en and clamps
    drive4(1, 15, 1, 0, 1, 0); cyc();
    expect4("load_clamp", 9, 0, 0);

    // Step above MAX_VAL clamps to 9; 0-1 wraps to 9; exact fit no cross
    drive4(1, 4, 0, 0, 0, 0); cyc();
    drive4(0, 0, 1, 0, 15, 0); cyc();
    expect4("step_clamp", 3, 1, 1);
    drive4(1, 0, 0, 0, 0, 0); cyc();
    drive4(0, 0, 1, 1, 1, 0); cyc();
    expect4("zero_minus1", 9, 1, 1);
    drive4(0, 0, 1, 1, 9, 0); cyc();
    expect4("exact_to_zero", 0, 0, 0);
    drive4(0, 0, 0, 0, 0, 0);

    // 8-bit full-range count
    bus8.load = 1'b1; bus8.load_val = '0; cyc();
    bus8.load = 1'b0; bus8.en = 1'b1; bus8.step = 8'd1;
    pulses   = 0;
    pulse_at = -1;
    for (int i = 0; i < 256; i++) begin
      cyc();
      if (bus8.tc) begin
        pulses++;
        pulse_at = i;
      end
    end
    bus8.en = 1'b0;
    chk("w8_tc_pulses", pulses, 1);
    chk("w8_tc_step", pulse_at, 255);
    chk("w8_final_count", int'(bus8.count), 0);
    cyc();
    chk("w8_idle_tc", int'(bus8.tc), 0);

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
